alu_exec_unit: RTL and testbench

- Execute-side consumer of the 4-bit ALU operation code produced by the ALU control decoder.
- Accepts one operation per cycle (op code plus two operands) over a valid/ready handshake and computes the result and flags.
- Buffers results in a small in-order output FIFO, so downstream backpressure never creates a combinational path back to the producer.
- Sits between ALU control / register read and writeback in the multi-cycle/pipelined RISC-V datapath.

---
 rtl/alu_exec_unit.sv | 164 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ALU execute stage: valid/ready op input, flag computation, in-order result FIFO.
// Holds DEPTH results so a stalled consumer never reaches back to the producer combinationally.

// Generic in-order FIFO with synchronous flush and reset-cleared storage.
// Latency: a push is visible at pop_dat one cycle later when the FIFO was empty.
// Backpressure: push_rdy comes from the registered count only, never from pop_rdy.
module alu_exec_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         flush,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign push_rdy = (count < FULL);
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];

    // flush wins over both sides of the handshake in the same cycle
    assign push = push_vld && push_rdy && !flush;
    assign pop  = pop_vld && pop_rdy && !flush;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Computes AND/OR/ADD/SUB result plus zero/carry/overflow/illegal and queues them.
// Latency: one cycle from accept to out_valid when the queue was empty; 1 op/cycle sustained.
// Backpressure: in_ready = queue not full (registered); independent of out_ready.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam int         MSB    = WIDTH - 1;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             carry;
        logic             overflow;
        logic             illegal;
    } res_t;

    res_t             exe_dat;
    res_t             head_dat;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             add_ovf;
    logic             sub_ovf;

    // SUB is a + ~b + 1 so its carry-out reads as "no borrow" (unsigned a >= b)
    assign add_sum = {1'b0, src_a} + {1'b0, src_b};
    assign sub_sum = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovf = (src_a[MSB] == src_b[MSB]) && (add_sum[MSB] != src_a[MSB]);
    assign sub_ovf = (src_a[MSB] != src_b[MSB]) && (sub_sum[MSB] != src_a[MSB]);

    always_comb begin
        exe_dat = '0;
        case (alu_op)
            OP_AND: exe_dat.result = src_a & src_b;
            OP_OR:  exe_dat.result = src_a | src_b;
            OP_ADD: begin
                exe_dat.result   = add_sum[WIDTH-1:0];
                exe_dat.carry    = add_sum[WIDTH];
                exe_dat.overflow = add_ovf;
            end
            OP_SUB: begin
                exe_dat.result   = sub_sum[WIDTH-1:0];
                exe_dat.carry    = sub_sum[WIDTH];
                exe_dat.overflow = sub_ovf;
            end
            default: begin
                // unsupported codes still produce an ADD so the pipe keeps moving
                exe_dat.result   = add_sum[WIDTH-1:0];
                exe_dat.carry    = add_sum[WIDTH];
                exe_dat.overflow = add_ovf;
                exe_dat.illegal  = 1'b1;
            end
        endcase
        exe_dat.zero = (exe_dat.result == '0);
    end

    alu_exec_fifo #(
        .W     ($bits(res_t)),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk      (clk),
        .n_rst    (n_rst),
        .flush    (flush),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (exe_dat),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head_dat)
    );

    assign result   = head_dat.result;
    assign zero     = head_dat.zero;
    assign carry    = head_dat.carry;
    assign overflow = head_dat.overflow;
    assign illegal  = head_dat.illegal;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: reset, flags, backpressure ordering, illegal op, flush.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        n_rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.WIDTH(32), .DEPTH(2)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        src_a    = a;
        src_b    = b;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 4'h0; src_a = '0; src_b = '0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_rst = 1'b1;
        tick();
        // buffer two entries, then reset mid-cycle
        offer(4'b0010, 32'd1, 32'd1);
        tick();
        offer(4'b0010, 32'd2, 32'd2);
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_prefill_full: in_ready got %b want 0", in_ready); end
        #2 n_rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready: got %b want 1", in_ready); end
        checks++; if ({result, zero, carry, overflow, illegal} !== 36'h0) begin
            errors++; $display("FAIL async_reset_fields: result %h flags %b%b%b%b want all 0", result, zero, carry, overflow, illegal);
        end
        #2 n_rst = 1'b1;
        offer(4'b0010, 32'd2, 32'd3);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'd5) begin
            errors++; $display("FAIL reset_then_add: out_valid %b result %h want 1 / 00000005", out_valid, result);
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_drain: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_add_flags();
        out_ready = 1'b1;
        offer(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'h8000_0000) begin
            errors++; $display("FAIL add_ovf_result: valid %b result %h want 1 / 80000000", out_valid, result);
        end
        checks++; if ({zero, carry, overflow, illegal} !== 4'b0010) begin
            errors++; $display("FAIL add_ovf_flags: zcoi %b want 0010", {zero, carry, overflow, illegal});
        end
        tick();
        offer(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
        tick();
        in_valid = 1'b0;
        checks++; if (result !== 32'h0 || {zero, carry, overflow, illegal} !== 4'b1100) begin
            errors++; $display("FAIL add_carry: result %h zcoi %b want 00000000 / 1100", result, {zero, carry, overflow, illegal});
        end
        tick();
    endtask

    task automatic test_sub_back_to_back();
        out_ready = 1'b1;
        offer(4'b0110, 32'd5, 32'd5);
        tick();
        checks++; if (result !== 32'h0 || {zero, carry, overflow, illegal} !== 4'b1100) begin
            errors++; $display("FAIL sub_equal: result %h zcoi %b want 00000000 / 1100", result, {zero, carry, overflow, illegal});
        end
        offer(4'b0110, 32'd3, 32'd5);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE || {zero, carry, overflow, illegal} !== 4'b0000) begin
            errors++; $display("FAIL sub_borrow: valid %b result %h zcoi %b want 1 / fffffffe / 0000",
                               out_valid, result, {zero, carry, overflow, illegal});
        end
        offer(4'b0110, 32'h8000_0000, 32'd1);
        tick();
        in_valid = 1'b0;
        checks++; if (result !== 32'h7FFF_FFFF || {zero, carry, overflow, illegal} !== 4'b0110) begin
            errors++; $display("FAIL sub_ovf: result %h zcoi %b want 7fffffff / 0110", result, {zero, carry, overflow, illegal});
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_drain: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_backpressure_order();
        out_ready = 1'b0;
        offer(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_one_entry: in_ready %b out_valid %b want 1 / 1", in_ready, out_valid);
        end
        offer(4'b0001, 32'h0000_F0F0, 32'h0000_0F0F);
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: in_ready %b want 0", in_ready); end
        offer(4'b0010, 32'd1, 32'd1);
        tick();
        checks++; if (in_ready !== 1'b0 || result !== 32'h0000_F000) begin
            errors++; $display("FAIL bp_held: in_ready %b result %h want 0 / 0000f000", in_ready, result);
        end
        out_ready = 1'b1;
        tick();
        // the first pop happened on a full cycle, so the ADD must still be waiting
        checks++; if (result !== 32'h0000_FFFF || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_first_pop: result %h in_ready %b valid %b want 0000ffff / 1 / 1", result, in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        checks++; if (result !== 32'h0000_0002 || out_valid !== 1'b1 || illegal !== 1'b0) begin
            errors++; $display("FAIL bp_add_after_pop: result %h valid %b illegal %b want 00000002 / 1 / 0", result, out_valid, illegal);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        offer(4'b0011, 32'd1, 32'd2);
        tick();
        in_valid = 1'b0;
        checks++; if (result !== 32'd3 || {zero, carry, overflow, illegal} !== 4'b0001) begin
            errors++; $display("FAIL illegal_op: result %h zcoi %b want 00000003 / 0001", result, {zero, carry, overflow, illegal});
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(4'b0010, 32'd7, 32'd8);
        tick();
        checks++; if (out_valid !== 1'b1 || result !== 32'd15) begin
            errors++; $display("FAIL flush_prefill: valid %b result %h want 1 / 0000000f", out_valid, result);
        end
        offer(4'b0010, 32'd9, 32'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_clear: out_valid %b in_ready %b want 0 / 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin
                errors++; $display("FAIL flush_no_ghost: cycle %0d out_valid %b want 0", i, out_valid);
            end
        end
        offer(4'b0001, 32'h0000_00A0, 32'h0000_000B);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'h0000_00AB) begin
            errors++; $display("FAIL flush_recover: valid %b result %h want 1 / 000000ab", out_valid, result);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add_flags();
        test_sub_back_to_back();
        test_backpressure_order();
        test_illegal();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
